// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader: loader/receiver
// state encodings, instruction and ROM address widths, default frame marker.
package uart_prog_loader_pkg;

    localparam int         INSTR_W       = 24;
    localparam int         ADDR_W        = 8;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN    = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_FINISH = 3'd4
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// ROM write port of the program loader. The loader is master; the ROM is slave.
// prog_w_enable is a single-cycle strobe with no back-pressure: the ROM must
// accept addr/data in the cycle it is high. Addr/data only change in that cycle.
interface uart_prog_loader_if;
    import uart_prog_loader_pkg::*;

    logic               prog_w_enable;
    logic [ADDR_W-1:0]  prog_w_addr;
    logic [INSTR_W-1:0] prog_w_data;

    modport master (
        output prog_w_enable,
        output prog_w_addr,
        output prog_w_data
    );

    modport slave (
        input prog_w_enable,
        input prog_w_addr,
        input prog_w_data
    );
endinterface

// File: rtl/uart_prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid on a good stop bit, one-cycle frame_err on a bad one.
module uart_prog_loader_uart_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int DIV = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err,
    output rx_state_t  o_dbg_state
);

    localparam int             CW      = (DIV > 2) ? $clog2(DIV) : 2;
    localparam logic [CW-1:0]  HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]  DIV_M1  = CW'(DIV - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    rx_state_t     r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_prev       <= 1'b1;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_state      <= RX_IDLE;
            o_byte_valid <= 1'b0;
            o_byte_data  <= '0;
            o_frame_err  <= 1'b0;
        end else begin
            r_sync1      <= i_rx;
            r_sync2      <= r_sync1;
            r_prev       <= r_sync2;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            case (r_state)
                // Only a true high-to-low edge starts a frame, so a line left
                // low after a bad stop bit does not retrigger.
                RX_IDLE: begin
                    if (!r_sync2 && r_prev) begin
                        r_cnt   <= '0;
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        r_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == DIV_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == DIV_M1) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) begin
                            o_byte_valid <= 1'b1;
                            o_byte_data  <= r_shift;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: receives SYNC, LEN, 3-byte words (and a checksum byte when
// LOADER_CHECKSUM_EN is defined) over UART and writes them into the ROM.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int         CLK_HZ     = 27000000,
    parameter int         BAUD       = 115200,
    parameter int         TIMEOUT_MS = 100,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    uart_prog_loader_if.master  prog,
    output logic                cpu_hold,
    output logic                loading,
    output logic                done,
    output logic                error,
    output ld_state_t           dbg_state,
    output rx_state_t           dbg_rx_state
);

    localparam int            DIV     = CLK_HZ / BAUD;
    localparam int            TO_CYC  = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int            TW      = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    logic               w_byte_valid;
    logic [7:0]         w_byte_data;
    logic               w_frame_err;
    logic               w_in_frame;
    logic               w_abort;

    ld_state_t          r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [8:0]         r_words_left;
    logic [1:0]         r_byte_cnt;
    logic [15:0]        r_word_lo;
    logic [TW-1:0]      r_timer;
    logic               r_we;
    logic [ADDR_W-1:0]  r_w_addr;
    logic [INSTR_W-1:0] r_w_data;
    logic               r_cpu_hold;
    logic               r_loading;
    logic               r_done;
    logic               r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    uart_prog_loader_uart_rx #(.DIV(DIV)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (rx),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_frame_err  (w_frame_err),
        .o_dbg_state  (dbg_rx_state)
    );

    assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_abort    = w_in_frame && (w_frame_err || (!w_byte_valid && r_timer == TO_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_words_left <= '0;
            r_byte_cnt   <= '0;
            r_word_lo    <= '0;
            r_timer      <= '0;
            r_we         <= 1'b0;
            r_w_addr     <= '0;
            r_w_data     <= '0;
            r_cpu_hold   <= 1'b0;
            r_loading    <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            // Inter-byte gap counter; only meaningful while a frame is open.
            if (!w_in_frame || w_byte_valid) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            // cpu_hold is deliberately left high so a partial image never runs.
            if (w_abort) begin
                r_error   <= 1'b1;
                r_loading <= 1'b0;
                r_state   <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte_valid && w_byte_data == SYNC_BYTE) begin
                            r_loading  <= 1'b1;
                            r_cpu_hold <= 1'b1;
                            r_error    <= 1'b0;
                            r_addr     <= '0;
                            r_byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_csum     <= '0;
`endif
                            r_state    <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (w_byte_valid) begin
                            r_words_left <= (w_byte_data == 8'd0) ? 9'd256 : {1'b0, w_byte_data};
                            r_byte_cnt   <= '0;
                            r_state      <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (w_byte_valid) begin
                            r_word_lo <= {r_word_lo[7:0], w_byte_data};
`ifdef LOADER_CHECKSUM_EN
                            r_csum    <= r_csum ^ w_byte_data;
`endif
                            if (r_byte_cnt == 2'd2) begin
                                r_byte_cnt   <= '0;
                                r_we         <= 1'b1;
                                r_w_addr     <= r_addr;
                                r_w_data     <= {r_word_lo, w_byte_data};
                                r_addr       <= r_addr + 1'b1;
                                r_words_left <= r_words_left - 9'd1;
                                if (r_words_left == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                    r_state <= ST_CSUM;
`else
                                    r_state <= ST_FINISH;
`endif
                                end
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CSUM: begin
                        if (w_byte_valid) begin
                            if (w_byte_data == r_csum) begin
                                r_state <= ST_FINISH;
                            end else begin
                                r_error   <= 1'b1;
                                r_loading <= 1'b0;
                                r_state   <= ST_IDLE;
                            end
                        end
                    end
`endif
                    ST_FINISH: begin
                        r_done     <= 1'b1;
                        r_loading  <= 1'b0;
                        r_cpu_hold <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign prog.prog_w_enable = r_we;
    assign prog.prog_w_addr   = r_w_addr;
    assign prog.prog_w_data   = r_w_data;
    assign cpu_hold           = r_cpu_hold;
    assign loading            = r_loading;
    assign done               = r_done;
    assign error              = r_error;
    assign dbg_state          = r_state;

endmodule
